// File: rtl/hist_eq_map_if.sv
// hist_eq_map_if: CDF load stream and pixel remap stream of hist_eq_map.
//   i_cdf_value/i_cdf_valid/o_cdf_ready : per-level cumulative counts, level 0..255 in order
//   i_pixel/i_pixel_valid               : pixel stream into the remapper
//   o_pixel/o_pixel_valid               : remapped pixel stream, one cycle later
//   o_lut_ready                         : a complete transfer table is active
// slave is the hist_eq_map side. master is the producer/consumer side.
interface hist_eq_map_if #(
    parameter int unsigned CDF_W = 19
) ();
    logic [CDF_W-1:0] i_cdf_value;
    logic             i_cdf_valid;
    logic             o_cdf_ready;
    logic [7:0]       i_pixel;
    logic             i_pixel_valid;
    logic [7:0]       o_pixel;
    logic             o_pixel_valid;
    logic             o_lut_ready;

    modport master (
        output i_cdf_value, i_cdf_valid, i_pixel, i_pixel_valid,
        input  o_cdf_ready, o_pixel, o_pixel_valid, o_lut_ready
    );

    modport slave (
        input  i_cdf_value, i_cdf_valid, i_pixel, i_pixel_valid,
        output o_cdf_ready, o_pixel, o_pixel_valid, o_lut_ready
    );
endinterface

// File: rtl/hist_eq_map.sv
// hist_eq_map: builds the histogram-equalization transfer function from a frame's
// CDF stream into a shadow LUT bank, swaps it in when complete, and remaps pixels.
//   i_clk   : rising-edge clock
//   i_reset : asynchronous active-high reset
//   bus     : hist_eq_map_if slave (CDF stream in, pixel stream in/out, o_lut_ready)
module hist_eq_map #(
    parameter int unsigned IMAGE_SIZE = 640 * 480
) (
    input  logic         i_clk,
    input  logic         i_reset,
    hist_eq_map_if.slave bus
);
    localparam int unsigned CDF_W = $clog2(IMAGE_SIZE + 1);
    localparam int unsigned NUM_W = CDF_W + 8;

    typedef enum logic [1:0] {IDLE, LOAD, DIV, WRITE} state_t;

    state_t           state;
    logic [7:0]       level;
    logic             write_bank;
    logic             active_bank;
    logic [CDF_W-1:0] cdf_min;
    logic             min_found;
    logic [2:0]       div_cnt;
    logic [CDF_W-1:0] rem;
    logic [CDF_W-1:0] den;
    logic [7:0]       num_lo;
    logic [7:0]       quot;
    logic             force_zero;
    logic             force_ident;
    logic             cdf_ready;
    logic             lut_ready;
    logic [7:0]       pixel_out;
    logic             pixel_valid;

    logic [7:0]       lut [0:1][0:255];

    logic             xfer_c;
    logic             take_min_c;
    logic [CDF_W-1:0] min_now_c;
    logic [CDF_W-1:0] diff_c;
    logic [NUM_W-1:0] num_c;
    logic [CDF_W-1:0] den_c;
    logic [CDF_W:0]   shifted_c;
    logic             fits_c;
    logic [CDF_W-1:0] rem_next_c;
    logic [7:0]       result_c;

    // Transfer-time setup (uses a freshly found cdf_min) and one restoring-division step.
    always_comb begin
        xfer_c     = cdf_ready & bus.i_cdf_valid;
        take_min_c = !min_found && (bus.i_cdf_value != '0);
        min_now_c  = take_min_c ? bus.i_cdf_value : cdf_min;
        diff_c     = bus.i_cdf_value - min_now_c;
        // diff * 255 as (diff << 8) - diff
        num_c      = (NUM_W'(diff_c) << 8) - NUM_W'(diff_c);
        den_c      = CDF_W'(IMAGE_SIZE) - min_now_c;
        // rem < den always holds, so the shifted partial remainder fits in CDF_W+1 bits
        shifted_c  = {rem, num_lo[7]};
        fits_c     = (shifted_c >= {1'b0, den});
        rem_next_c = fits_c ? CDF_W'(shifted_c - {1'b0, den}) : shifted_c[CDF_W-1:0];
        if (force_zero) begin
            result_c = 8'd0;
        end else if (force_ident) begin
            result_c = level;
        end else begin
            result_c = quot;
        end
    end

    // Load FSM, division datapath, bank control and pixel remap.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            level       <= 8'd0;
            write_bank  <= 1'b1;
            active_bank <= 1'b0;
            cdf_min     <= '0;
            min_found   <= 1'b0;
            div_cnt     <= 3'd0;
            rem         <= '0;
            den         <= '0;
            num_lo      <= 8'd0;
            quot        <= 8'd0;
            force_zero  <= 1'b0;
            force_ident <= 1'b0;
            cdf_ready   <= 1'b0;
            lut_ready   <= 1'b0;
            pixel_out   <= 8'd0;
            pixel_valid <= 1'b0;
        end else begin
            pixel_valid <= bus.i_pixel_valid;
            if (bus.i_pixel_valid) begin
                pixel_out <= lut_ready ? lut[active_bank][bus.i_pixel] : bus.i_pixel;
            end

            case (state)
                IDLE: begin
                    state     <= LOAD;
                    cdf_ready <= 1'b1;
                end
                LOAD: begin
                    if (xfer_c) begin
                        if (take_min_c) begin
                            cdf_min   <= bus.i_cdf_value;
                            min_found <= 1'b1;
                        end
                        // quotient < 256, so the upper numerator bits start below den
                        rem         <= num_c[NUM_W-1:8];
                        num_lo      <= num_c[7:0];
                        den         <= den_c;
                        quot        <= 8'd0;
                        force_zero  <= (bus.i_cdf_value == '0);
                        force_ident <= (den_c == '0);
                        div_cnt     <= 3'd0;
                        cdf_ready   <= 1'b0;
                        state       <= DIV;
                    end
                end
                DIV: begin
                    rem     <= rem_next_c;
                    num_lo  <= {num_lo[6:0], 1'b0};
                    quot    <= {quot[6:0], fits_c};
                    div_cnt <= div_cnt + 3'd1;
                    if (div_cnt == 3'd7) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    level     <= level + 8'd1;
                    cdf_ready <= 1'b1;
                    state     <= LOAD;
                    if (level == 8'd255) begin
                        active_bank <= write_bank;
                        write_bank  <= active_bank;
                        lut_ready   <= 1'b1;
                        min_found   <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cdf_ready <= 1'b0;
                end
            endcase
        end
    end

    // LUT storage; contents are not reset, only the shadow bank is ever written.
    always_ff @(posedge i_clk) begin
        if (state == WRITE) begin
            lut[write_bank][level] <= result_c;
        end
    end

    assign bus.o_cdf_ready   = cdf_ready;
    assign bus.o_lut_ready   = lut_ready;
    assign bus.o_pixel       = pixel_out;
    assign bus.o_pixel_valid = pixel_valid;
endmodule
